// File: rtl/sc_mul_share_ctrl.sv
// sc_mul_share_ctrl: time-shares one stochastic-computing multiplier among
// NUM_REQ requesters. Operands are accepted over per-requester valid/ready,
// held on mul_a/mul_b for MUL_CYCLES cycles (the bitstream evaluation
// window), and the sampled product is returned with the requester ID over a
// valid/ready response port.
//
// Optional build macro SC_MUL_ZERO_BYPASS_EN: a granted request with a zero
// operand skips the multiplier and answers with 0 on the next cycle.
module sc_mul_share_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MUL_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    input  logic [OUT_WIDTH-1:0]          mul_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [OUT_WIDTH-1:0]          rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic [ID_WIDTH-1:0]     id_q;

    logic                    grant_valid;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic [ID_WIDTH-1:0]     grant_id;
    logic [DATA_WIDTH-1:0]   grant_a;
    logic [DATA_WIDTH-1:0]   grant_b;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign grant_id = ID_WIDTH'(grant_idx);
    assign grant_a  = req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign grant_b  = req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // Accept is offered only in IDLE, and only to the round-robin winner.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Multiplier inputs come straight from the operand registers so they only
    // toggle on capture; status flags decode directly from the state register.
    assign mul_a     = op_a;
    assign mul_b     = op_b;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Sequencer: capture -> hold for MUL_CYCLES -> sample -> hand off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            id_q     <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        rr_ptr <= next_ptr;
`ifdef SC_MUL_ZERO_BYPASS_EN
                        if (grant_a == '0 || grant_b == '0) begin
                            rsp_data <= '0;
                            rsp_id   <= grant_id;
                            state    <= DONE;
                        end else
`endif
                        begin
                            op_a  <= grant_a;
                            op_b  <= grant_b;
                            id_q  <= grant_id;
                            cnt   <= CNT_W'(MUL_CYCLES - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_data <= mul_result;
                        rsp_id   <= id_q;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mul_share_ctrl.sv
// Self-checking bench for sc_mul_share_ctrl: directed scenarios plus a
// randomized run, all compared against a transaction-level model of the
// arbiter (round-robin pointer, per-operation countdown, expected product).
// A second instance with MUL_CYCLES=1 covers the shortest hold window.
module tb_sc_mul_share_ctrl;

    localparam int DW = 16;
    localparam int OW = 2 * DW;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int MC = 4;

    logic            clk;
    logic            rst_n;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic [OW-1:0]   mul_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [OW-1:0]   rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    logic [N-1:0]    d1_req_valid;
    logic [N-1:0]    d1_req_ready;
    logic [N*DW-1:0] d1_req_a;
    logic [N*DW-1:0] d1_req_b;
    logic [DW-1:0]   d1_mul_a;
    logic [DW-1:0]   d1_mul_b;
    logic [OW-1:0]   d1_mul_result;
    logic            d1_rsp_valid;
    logic            d1_rsp_ready;
    logic [OW-1:0]   d1_rsp_data;
    logic [IW-1:0]   d1_rsp_id;
    logic            d1_busy;

    // Shared multiplier stand-ins: plain combinational products.
    assign mul_result    = {16'b0, mul_a} * {16'b0, mul_b};
    assign d1_mul_result = {16'b0, d1_mul_a} * {16'b0, d1_mul_b};

    sc_mul_share_ctrl #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_REQ(N), .ID_WIDTH(IW), .MUL_CYCLES(MC)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    sc_mul_share_ctrl #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_REQ(N), .ID_WIDTH(IW), .MUL_CYCLES(1)
    ) u_dut_mc1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d1_req_valid), .req_ready(d1_req_ready),
        .req_a(d1_req_a), .req_b(d1_req_b),
        .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_result(d1_mul_result),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready),
        .rsp_data(d1_rsp_data), .rsp_id(d1_rsp_id), .busy(d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: phase 0 waiting, 1 multiplying, 2 answering.
    int            m_phase;
    int            m_wait;
    int            m_ptr;
    int            m_id;
    logic [31:0]   m_data;
    logic [15:0]   m_opa;
    logic [15:0]   m_opb;
    int            n_rsp;
    int            grant_log[$];

    task automatic model_reset();
        m_phase = 0;
        m_wait  = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_data  = '0;
        m_opa   = '0;
        m_opb   = '0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model across the next rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] a,
                        input logic [N*DW-1:0] b, input logic rr);
        int         g;
        logic [N-1:0] exp_ready;
        logic [15:0] ga;
        logic [15:0] gb;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (g < 0 && v[i]) g = i;
        end
        exp_ready = '0;
        if (m_phase == 0 && g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("busy", busy, m_phase != 0);
        check("rsp_valid", rsp_valid, m_phase == 2);
        check("mul_a", mul_a, m_opa);
        check("mul_b", mul_b, m_opb);
        if (m_phase == 2) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
        end
        case (m_phase)
            0: if (g >= 0) begin
                ga = a[g*DW +: DW];
                gb = b[g*DW +: DW];
                grant_log.push_back(g);
                m_id  = g;
                m_ptr = (g + 1) % N;
`ifdef SC_MUL_ZERO_BYPASS_EN
                if (ga == 0 || gb == 0) begin
                    m_data  = '0;
                    m_phase = 2;
                end else
`endif
                begin
                    m_opa   = ga;
                    m_opb   = gb;
                    m_data  = 32'(ga) * 32'(gb);
                    m_wait  = MC;
                    m_phase = 1;
                end
            end
            1: begin
                m_wait--;
                if (m_wait == 0) m_phase = 2;
            end
            default: if (rr) begin
                m_phase = 0;
                n_rsp++;
            end
        endcase
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [N*DW-1:0] va;
        logic [N*DW-1:0] vb;
        int              rsp_before;

        rst_n        = 1'b0;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        rsp_ready    = 1'b0;
        d1_req_valid = '0;
        d1_req_a     = '0;
        d1_req_b     = '0;
        d1_rsp_ready = 1'b1;
        n_rsp        = 0;
        model_reset();

        // Reset values.
        #12;
        check("rst busy", busy, 1'b0);
        check("rst rsp_valid", rsp_valid, 1'b0);
        check("rst req_ready", req_ready, '0);
        check("rst rsp_data", rsp_data, '0);
        check("rst rsp_id", rsp_id, '0);
        check("rst mul_a", mul_a, '0);
        check("rst d1 busy", d1_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesters valid: grants rotate 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            va[i*DW +: DW] = 16'(i + 1);
            vb[i*DW +: DW] = 16'(100 + i);
        end
        grant_log.delete();
        for (int c = 0; c < 30; c++) step(4'hF, va, vb, 1'b1);
        check("rr grant count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) check("rr grant order", grant_log[i], i % N);
        for (int c = 0; c < 8; c++) step('0, va, vb, 1'b1);

        // Single request from requester 1: 3*5.
        va = '0;
        vb = '0;
        va[1*DW +: DW] = 16'd3;
        vb[1*DW +: DW] = 16'd5;
        rsp_before = n_rsp;
        step(4'b0010, va, vb, 1'b1);
        for (int c = 0; c < 7; c++) step('0, va, vb, 1'b1);
        check("single rsp count", n_rsp - rsp_before, 1);
        check("single product model", m_data, 32'd15);

        // Backpressure: hold DONE for 10 cycles while others keep requesting.
        va[2*DW +: DW] = 16'd7;
        vb[2*DW +: DW] = 16'd11;
        step(4'b0100, va, vb, 1'b0);
        for (int c = 0; c < MC; c++) step(4'b1011, va, vb, 1'b0);
        rsp_before = n_rsp;
        for (int c = 0; c < 10; c++) step(4'hF, va, vb, 1'b0);
        check("bp no rsp while held", n_rsp - rsp_before, 0);
        step('0, va, vb, 1'b1);
        for (int c = 0; c < 4; c++) step('0, va, vb, 1'b1);
        check("bp one rsp", n_rsp - rsp_before, 1);

        // Zero operand on requester 0 (bypass or normal path per build).
        va = '0;
        vb = '0;
        vb[0*DW +: DW] = 16'd9;
        rsp_before = n_rsp;
        step(4'b0001, va, vb, 1'b1);
        for (int c = 0; c < 7; c++) step('0, va, vb, 1'b1);
        check("zero rsp count", n_rsp - rsp_before, 1);

        // Reset mid-operation (cnt == 2) discards the operation.
        va[2*DW +: DW] = 16'd21;
        vb[2*DW +: DW] = 16'd2;
        step(4'b0100, va, vb, 1'b1);
        step('0, va, vb, 1'b1);
        @(negedge clk);
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid rst busy", busy, 1'b0);
        check("mid rst rsp_valid", rsp_valid, 1'b0);
        check("mid rst mul_a", mul_a, '0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_before = n_rsp;
        grant_log.delete();
        for (int c = 0; c < 8; c++) step('0, va, vb, 1'b1);
        check("mid rst no rsp", n_rsp - rsp_before, 0);
        va = '0;
        vb = '0;
        for (int i = 0; i < N; i++) begin
            va[i*DW +: DW] = 16'(10 + i);
            vb[i*DW +: DW] = 16'(3);
        end
        step(4'hF, va, vb, 1'b1);
        check("mid rst grant from 0", grant_log[0], 0);
        for (int c = 0; c < 8; c++) step('0, va, vb, 1'b1);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                va[i*DW +: DW] = rand_op();
                vb[i*DW +: DW] = rand_op();
            end
            step(N'($urandom), va, vb, $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 12; c++) step('0, va, vb, 1'b1);
        check("random drained", m_phase, 0);

        // MUL_CYCLES=1 instance: 0xFFFF * 2 two cycles after accept.
        @(negedge clk);
        d1_req_valid = 4'b0001;
        d1_req_a[0*DW +: DW] = 16'hFFFF;
        d1_req_b[0*DW +: DW] = 16'h0002;
        #1;
        check("mc1 req_ready", d1_req_ready, 4'b0001);
        @(negedge clk);
        d1_req_valid = '0;
        #1;
        check("mc1 busy", d1_busy, 1'b1);
        check("mc1 rsp_valid early", d1_rsp_valid, 1'b0);
        check("mc1 mul_a", d1_mul_a, 16'hFFFF);
        @(negedge clk);
        #1;
        check("mc1 rsp_valid", d1_rsp_valid, 1'b1);
        check("mc1 rsp_data", d1_rsp_data, 32'h0001FFFE);
        check("mc1 rsp_id", d1_rsp_id, 0);
        @(negedge clk);
        #1;
        check("mc1 back to idle", d1_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
